// File: rtl/rmii_frame_tx_if.sv
// Byte-stream input and RMII output bundle for rmii_frame_tx.
// master = upstream queue / observer side, slave = the MAC.
interface rmii_frame_tx_if;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_last;
  logic       s_ready;
  logic       tx_en;
  logic [1:0] tx_data;
  logic       busy;
  logic       underrun;
  logic       truncated;

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready, tx_en, tx_data, busy, underrun, truncated
  );

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready, tx_en, tx_data, busy, underrun, truncated
  );
endinterface

// File: rtl/rmii_frame_tx.sv
// RMII transmit MAC: preamble/SFD, payload with zero padding and truncation, inter-frame gap.
// Define RMII_TX_FCS_EN to build the CRC-32 generator and append the 4-octet FCS.
module rmii_frame_tx #(
  parameter int PREAMBLE_OCTETS = 7,
  parameter int IFG_OCTETS      = 12,
  parameter int MIN_PAYLOAD     = 60,
  parameter int MAX_PAYLOAD     = 1514
) (
  input  logic            clk,
  input  logic            rst,
  rmii_frame_tx_if.slave  bus
);
  localparam int PRE_CYC  = PREAMBLE_OCTETS * 4;
  localparam int IFG_CYC  = IFG_OCTETS * 4;
  localparam int CNT_SPAN = (PRE_CYC > IFG_CYC) ? PRE_CYC : IFG_CYC;
  localparam int CNT_W    = $clog2((CNT_SPAN > 16) ? CNT_SPAN : 16);
  localparam int OCT_W    = $clog2(MAX_PAYLOAD + 1);

  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRE_CYC - 1);
  localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_CYC - 1);
  localparam logic [CNT_W-1:0] FCS_LAST = CNT_W'(15);
  localparam logic [OCT_W-1:0] MIN_CNT  = OCT_W'(MIN_PAYLOAD);
  localparam logic [OCT_W-1:0] MAX_CNT  = OCT_W'(MAX_PAYLOAD);
  localparam logic [OCT_W-1:0] TRUNC_AT = OCT_W'(MAX_PAYLOAD - 1);

  typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IFG} state_t;

`ifdef RMII_TX_FCS_EN
  localparam state_t TAIL = FCS;
`else
  localparam state_t TAIL = IFG;
`endif

  // state_q/cnt_q describe the dibit currently on the wire; outputs are registered from the next values
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OCT_W-1:0] octet_cnt_q, octet_cnt_d;
  logic [7:0]       hold_q, hold_d;
  logic             last_q, last_d;
  logic             tx_en_q, tx_en_d;
  logic [1:0]       tx_data_q, tx_data_d;
  logic             underrun_q, underrun_d;
  logic             truncated_q, truncated_d;
  logic             at_end;
  logic             s_ready_int;
  logic [OCT_W-1:0] octet_inc;

`ifdef RMII_TX_FCS_EN
  logic [31:0] crc_q, crc_d;
  logic [31:0] fcs_word;

  // Reflected CRC-32, two bits per call, bit 0 of the dibit first
  function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 2; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  always_comb begin
    crc_d = crc_q;
    if (state_q == SFD) begin
      crc_d = '1;
    end else if (state_q == DATA || state_q == PAD) begin
      crc_d = crc_dibit(crc_q, tx_data_q);
    end
  end

  assign fcs_word = ~crc_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) crc_q <= '1;
    else     crc_q <= crc_d;
  end
`endif

  assign at_end    = (cnt_q[1:0] == 2'd3);
  assign octet_inc = (octet_cnt_q == MAX_CNT) ? octet_cnt_q : octet_cnt_q + 1'b1;

  always_comb begin
    s_ready_int = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE:    s_ready_int = 1'b1;
        DATA:    s_ready_int = at_end && !last_q;
        default: s_ready_int = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    octet_cnt_d = octet_cnt_q;
    hold_d      = hold_q;
    last_d      = last_q;
    underrun_d  = 1'b0;
    truncated_d = 1'b0;
    tx_en_d     = 1'b0;
    tx_data_d   = 2'b00;

    case (state_q)
      IDLE: begin
        if (bus.s_valid && s_ready_int) begin
          hold_d  = bus.s_data;
          last_d  = bus.s_last;
          cnt_d   = '0;
          state_d = PREAMBLE;
        end
      end
      PREAMBLE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == PRE_LAST) begin
          cnt_d   = '0;
          state_d = SFD;
        end
      end
      SFD: begin
        octet_cnt_d = '0;
        cnt_d       = cnt_q + 1'b1;
        if (at_end) begin
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (at_end) begin
          cnt_d       = '0;
          octet_cnt_d = octet_inc;
          if (last_q) begin
            state_d = (octet_inc < MIN_CNT) ? PAD : TAIL;
          end else if (bus.s_valid) begin
            hold_d = bus.s_data;
            last_d = bus.s_last;
            // The octet just accepted is number MAX_PAYLOAD: force it to close the frame
            if (!bus.s_last && octet_inc == TRUNC_AT) begin
              last_d      = 1'b1;
              truncated_d = 1'b1;
            end
          end else begin
            underrun_d = 1'b1;
            state_d    = IFG;
          end
        end
      end
      PAD: begin
        cnt_d = cnt_q + 1'b1;
        if (at_end) begin
          cnt_d       = '0;
          octet_cnt_d = octet_inc;
          if (octet_inc >= MIN_CNT) state_d = TAIL;
        end
      end
      FCS: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == FCS_LAST) begin
          cnt_d   = '0;
          state_d = IFG;
        end
      end
      IFG: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == IFG_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Decode the dibit for the next cycle from the next state
    case (state_d)
      PREAMBLE: begin
        tx_en_d   = 1'b1;
        tx_data_d = 2'b01;
      end
      SFD: begin
        tx_en_d   = 1'b1;
        tx_data_d = (cnt_d[1:0] == 2'd3) ? 2'b11 : 2'b01;
      end
      DATA: begin
        tx_en_d   = 1'b1;
        tx_data_d = hold_d[{cnt_d[1:0], 1'b0} +: 2];
      end
      PAD: begin
        tx_en_d   = 1'b1;
        tx_data_d = 2'b00;
      end
      FCS: begin
        tx_en_d = 1'b1;
`ifdef RMII_TX_FCS_EN
        tx_data_d = fcs_word[{cnt_d[3:0], 1'b0} +: 2];
`else
        tx_data_d = 2'b00;
`endif
      end
      default: begin
        tx_en_d   = 1'b0;
        tx_data_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      octet_cnt_q <= '0;
      hold_q      <= '0;
      last_q      <= 1'b0;
      tx_en_q     <= 1'b0;
      tx_data_q   <= 2'b00;
      underrun_q  <= 1'b0;
      truncated_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      octet_cnt_q <= octet_cnt_d;
      hold_q      <= hold_d;
      last_q      <= last_d;
      tx_en_q     <= tx_en_d;
      tx_data_q   <= tx_data_d;
      underrun_q  <= underrun_d;
      truncated_q <= truncated_d;
    end
  end

  assign bus.s_ready   = s_ready_int;
  assign bus.tx_en     = tx_en_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.underrun  = underrun_q;
  assign bus.truncated = truncated_q;
endmodule
